// File: rtl/brick_map_ctrl.sv
// brick_map_ctrl: live brick matrix for the current level.
// Copies a selected 15x20 static level map one row per cycle, tracks the
// number of live bricks, clears bricks on bullet hits and answers per-pixel
// "brick here" lookups for the VGA drawing path.
module brick_map_ctrl #(
  parameter int TILE_W = 32,
  parameter int TILE_H = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [0:14][0:19]  mat_in0,
  input  logic [0:14][0:19]  mat_in1,
  input  logic [0:14][0:19]  mat_in2,
  input  logic [0:14][0:19]  mat_in3,
  input  logic [1:0]         level_sel,
  input  logic               load,
  output logic               load_busy,
  input  logic               hit_valid,
  input  logic [3:0]         hit_row,
  input  logic [4:0]         hit_col,
  output logic               hit_ack,
  output logic               hit_was_brick,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  output logic               brick_draw,
  output logic [8:0]         brick_count,
  output logic               all_clear
);

  localparam int COL_SH = $clog2(TILE_W);
  localparam int ROW_SH = $clog2(TILE_H);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         row_q, row_d;
  logic [0:14][0:19]  live_q, live_d;
  logic [8:0]         count_q, count_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               was_q, was_d;
  logic               draw_q, draw_d;
  logic               clear_q, clear_d;

  logic [0:19]        map_row;
  logic [4:0]         pix_col;
  logic [3:0]         pix_row;
  logic               hit_ok;

  // Number of bricks in one map row (0..20).
  function automatic logic [4:0] row_pop(input logic [0:19] row);
    logic [4:0] pop;
    pop = '0;
    for (int i = 0; i < 20; i++) begin
      pop = pop + {4'd0, row[i]};
    end
    return pop;
  endfunction

  // Row being copied from the latched level map.
  always_comb begin
    map_row = '0;
    case (sel_q)
      2'd0:    map_row = mat_in0[row_q];
      2'd1:    map_row = mat_in1[row_q];
      2'd2:    map_row = mat_in2[row_q];
      default: map_row = mat_in3[row_q];
    endcase
  end

  // Next-state logic: load has priority; copy in LOAD; hits only land in READY.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    row_d   = row_q;
    live_d  = live_q;
    count_d = count_q;
    ack_d   = hit_valid;
    was_d   = 1'b0;
    pix_col = pixelX[COL_SH +: 5];
    pix_row = pixelY[ROW_SH +: 4];
    hit_ok  = (hit_row <= 4'd14) && (hit_col <= 5'd19) && live_q[hit_row][hit_col];

    if (load) begin
      sel_d   = level_sel;
      live_d  = '0;
      count_d = '0;
      row_d   = '0;
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD: begin
          live_d[row_q] = map_row;
          count_d       = count_q + {4'd0, row_pop(map_row)};
          row_d         = row_q + 4'd1;
          if (row_q == 4'd14) state_d = READY;
        end
        READY: begin
          if (hit_valid && hit_ok) begin
            live_d[hit_row][hit_col] = 1'b0;
            count_d                  = count_q - 9'd1;
            was_d                    = 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d  = (state_d == LOAD);
    // Lookup and all-clear both observe the pre-update matrix and count.
    clear_d = (state_q == READY) && (count_q == 9'd0);
    draw_d  = 1'b0;
    if ((pixelX < 11'd640) && (pixelY < 11'd480)) draw_d = live_q[pix_row][pix_col];
  end

  // State and registered outputs; reset clears everything, dropping any pending ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      row_q   <= '0;
      live_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      was_q   <= 1'b0;
      draw_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      live_q  <= live_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      was_q   <= was_d;
      draw_q  <= draw_d;
      clear_q <= clear_d;
    end
  end

  assign load_busy     = busy_q;
  assign hit_ack       = ack_q;
  assign hit_was_brick = was_q;
  assign brick_draw    = draw_q;
  assign brick_count   = count_q;
  assign all_clear     = clear_q;

endmodule

// File: tb/tb_brick_map_ctrl.sv
// Testbench for brick_map_ctrl: directed test-plan sequences followed by
// randomized traffic, scored against a matrix-level reference model.
module tb_brick_map_ctrl;

  logic              clk = 1'b0;
  logic              reset, load, hit_valid;
  logic [1:0]        level_sel;
  logic [3:0]        hit_row;
  logic [4:0]        hit_col;
  logic [10:0]       pixelX, pixelY;
  logic [0:14][0:19] mat_in0, mat_in1, mat_in2, mat_in3;
  logic              load_busy, hit_ack, hit_was_brick, brick_draw, all_clear;
  logic [8:0]        brick_count;

  always #5 clk = ~clk;

  brick_map_ctrl #(.TILE_W(32), .TILE_H(32)) dut (
    .clk(clk), .reset(reset),
    .mat_in0(mat_in0), .mat_in1(mat_in1), .mat_in2(mat_in2), .mat_in3(mat_in3),
    .level_sel(level_sel), .load(load), .load_busy(load_busy),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .hit_ack(hit_ack), .hit_was_brick(hit_was_brick),
    .pixelX(pixelX), .pixelY(pixelY), .brick_draw(brick_draw),
    .brick_count(brick_count), .all_clear(all_clear)
  );

  typedef struct {
    bit ack;
    bit was;
    bit draw;
    bit busy;
    bit clr;
    int cnt;
  } exp_t;

  exp_t q[$];

  // Reference model: level maps, live matrix, and a coarse phase
  // (0 = no level, 1 = copying, 2 = playable).
  bit mp[4][15][20];
  bit live[15][20];
  int phase = 0;
  int rows_done = 0;
  int msel = 0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int total();
    int s = 0;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++)
        s += live[r][c];
    return s;
  endfunction

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model one clock edge from the currently driven inputs, then queue the
  // outputs expected after that edge.
  task automatic tick();
    exp_t e;
    e = '{ack: 0, was: 0, draw: 0, busy: 0, clr: 0, cnt: 0};
    if (reset) begin
      for (int r = 0; r < 15; r++)
        for (int c = 0; c < 20; c++)
          live[r][c] = 0;
      phase = 0;
      rows_done = 0;
    end else begin
      e.ack  = hit_valid;
      e.draw = (pixelX < 640 && pixelY < 480) ? live[pixelY / 32][pixelX / 32] : 1'b0;
      e.clr  = (phase == 2) && (total() == 0);
      if (load) begin
        msel = level_sel;
        for (int r = 0; r < 15; r++)
          for (int c = 0; c < 20; c++)
            live[r][c] = 0;
        phase = 1;
        rows_done = 0;
      end else if (phase == 1) begin
        for (int c = 0; c < 20; c++) live[rows_done][c] = mp[msel][rows_done][c];
        rows_done++;
        if (rows_done == 15) phase = 2;
      end else if (phase == 2 && hit_valid && hit_row < 15 && hit_col < 20
                   && live[hit_row][hit_col]) begin
        live[hit_row][hit_col] = 0;
        e.was = 1;
      end
      e.cnt  = total();
      e.busy = (phase == 1);
    end
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  task automatic drv(input bit rst, input bit l, input int s, input bit hv,
                     input int hr, input int hc, input int px, input int py);
    reset     = rst;
    load      = l;
    level_sel = s[1:0];
    hit_valid = hv;
    hit_row   = hr[3:0];
    hit_col   = hc[4:0];
    pixelX    = px[10:0];
    pixelY    = py[10:0];
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drv(0, 0, 0, 0, 0, 0, $urandom_range(0, 799), $urandom_range(0, 599));
  endtask

  // Monitor: every cycle with a pending expectation, compare all outputs.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hit_ack", hit_ack, e.ack);
      if (e.ack) chk("hit_was_brick", hit_was_brick, e.was);
      chk("brick_draw", brick_draw, e.draw);
      chk("load_busy", load_busy, e.busy);
      chk("all_clear", all_clear, e.clr);
      chk("brick_count", brick_count, e.cnt);
    end
  end

  initial begin
    // Maps: 0 checkerboard with (0,0)=1, 1 single brick at (14,19), 2 all ones, 3 random.
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++) begin
        mp[0][r][c] = ((r + c) % 2 == 0);
        mp[1][r][c] = (r == 14 && c == 19);
        mp[2][r][c] = 1'b1;
        mp[3][r][c] = $urandom_range(0, 1);
        mat_in0[r][c] = mp[0][r][c];
        mat_in1[r][c] = mp[1][r][c];
        mat_in2[r][c] = mp[2][r][c];
        mat_in3[r][c] = mp[3][r][c];
      end

    drv(1, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Full map: 15 busy cycles, 300 bricks.
    drv(0, 1, 2, 0, 0, 0, 0, 0);
    idle(18);

    // Checkerboard and pixel probes.
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    idle(16);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 32, 0);
    drv(0, 0, 0, 0, 0, 0, 700, 100);
    drv(0, 0, 0, 0, 0, 0, 639, 479);

    // Back-to-back hits on one cell, with a lookup on that cell in the same cycle.
    drv(0, 0, 0, 1, 0, 0, 5, 5);
    drv(0, 0, 0, 1, 0, 0, 5, 5);
    drv(0, 0, 0, 0, 0, 0, 5, 5);
    drv(0, 0, 0, 0, 0, 0, 5, 5);

    // Out-of-range hits.
    drv(0, 0, 0, 1, 15, 3, 0, 0);
    drv(0, 0, 0, 1, 2, 25, 0, 0);
    idle(2);

    // Reload mid-copy with a simultaneous hit, then clear the single brick.
    drv(0, 1, 2, 0, 0, 0, 0, 0);
    idle(7);
    drv(0, 1, 1, 1, 0, 0, 0, 0);
    idle(16);
    drv(0, 0, 0, 1, 14, 19, 639, 479);
    idle(4);

    // Reset during the copy of row 9.
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    idle(9);
    drv(1, 0, 0, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 40, 40);
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit l, hv, rst;
      int hr, hc;
      rst = ($urandom_range(0, 499) == 0);
      l   = ($urandom_range(0, 59) == 0);
      hv  = ($urandom_range(0, 9) < 4);
      hr  = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 15) : $urandom_range(0, 14);
      hc  = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19);
      if ((i % 700) == 650) begin
        // Sweep the remaining bricks of the single-brick map to reach all_clear.
        drv(0, 1, 1, 0, 0, 0, 0, 0);
        idle(16);
        drv(0, 0, 0, 1, 14, 19, 0, 0);
        idle(3);
      end else begin
        drv(rst, l, $urandom_range(0, 3), hv, hr, hc,
            $urandom_range(0, 799), $urandom_range(0, 599));
      end
    end

    reset = 0; load = 0; hit_valid = 0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
